// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// It produces the stage enables, flushes and bubbles, and the forwarding and
// bypass selects. It also runs the data-memory wait FSM with a watchdog and
// keeps the saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic             ex_load,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic             mem_valid,
    input  logic             mem_load,
    input  logic             mem_memop,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic             mem_ready,
    input  logic             redirect,
    input  logic             wb_valid,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_t;

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MAX_WAIT);

    state_t            state_q;
    logic [WCNT_W-1:0] wait_cnt;
    logic              mem_busy;
    logic              wait_expired;
    logic              memstall;
    logic              load_use;
    logic              take_redirect;

    // A result in MEM can be forwarded only if it is not a load, because load
    // data is not available until WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (mem_valid && mem_regwrite && !mem_load && (mem_rd != 5'd0) && (mem_rd == rs))
            return 2'b01;
        else if (wb_valid && wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic wb_hit(input logic [4:0] rs);
        return wb_valid && wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign mem_busy = mem_valid && mem_memop && !mem_ready;
    // On the last allowed wait cycle the watchdog treats the access as done.
    assign wait_expired = (state_q == MEM_WAIT) && mem_busy && (wait_cnt == WAIT_LIMIT);
    assign memstall = mem_busy && !wait_expired;
    assign load_use = ex_valid && ex_load && ex_regwrite && (ex_rd != 5'd0) && id_valid &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Stage control decision: reset > memory freeze > redirect > load-use > normal.
    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_flush   = 1'b0;
        memwb_bubble  = 1'b0;
        take_redirect = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (memstall) begin
            // MEM holds its instruction, so a pending redirect comes back after release.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (redirect) begin
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            exmem_flush   = 1'b1;
            take_redirect = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign fwd_a    = rst ? 2'b00 : fwd_sel(ex_rs1);
    assign fwd_b    = rst ? 2'b00 : fwd_sel(ex_rs2);
    assign id_byp_a = !rst && wb_hit(id_rs1);
    assign id_byp_b = !rst && wb_hit(id_rs2);
    assign state    = state_q;

    // Memory wait FSM with watchdog; the timeout flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        state_q  <= MEM_WAIT;
                        wait_cnt <= WCNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        state_q  <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        state_q     <= RUN;
                        wait_cnt    <= '0;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters for stalled cycles and taken redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_en)
                stall_count <= sat_inc(stall_count);
            if (take_redirect)
                flush_count <= sat_inc(flush_count);
        end
    end

endmodule
